// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture block.
//   pwm_state_e : measurement FSM states
//   cnt_width() : measurement width derived from the counter resolution
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pwm_state_e;

    // One extra bit so a full 2^RESOLUTION period fits without wrapping.
    function automatic int unsigned cnt_width(input int unsigned resolution);
        return resolution + 1;
    endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// Synchronizes the asynchronous PWM input and produces registered
// single-cycle rise/fall strobes.
//   clk    : clock
//   rst    : synchronous active-low reset
//   pwm_in : asynchronous PWM waveform
//   rise   : one-cycle strobe on a synchronized 0->1 transition
//   fall   : one-cycle strobe on a synchronized 1->0 transition
module pwm_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic rise,
    output logic fall
);

    // Strobes stay masked until the chain and the edge register hold real
    // samples, so the reset zeros are never mistaken for an observed low.
    localparam int unsigned ARM_CNT = SYNC_STAGES + 1;
    localparam int unsigned FILL_W  = $clog2(ARM_CNT + 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic [FILL_W-1:0]      fill;
    logic                   armed;
    logic                   level;

    assign armed = (fill == FILL_W'(ARM_CNT));
    assign level = sync[SYNC_STAGES-1];

    // Synchronizer chain, edge register and strobe registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync <= '0;
            prev <= 1'b0;
            fill <= '0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pwm_in};
            prev <= level;
            if (!armed) begin
                fill <= fill + FILL_W'(1);
            end
            rise <= armed &  level & ~prev;
            fall <= armed & ~level &  prev;
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM input in clk cycles.
//   clk        : clock, all logic on the rising edge
//   rst        : synchronous active-low reset
//   pwm_in     : asynchronous PWM waveform
//   period_cnt : cycles between the last two rising edges
//   high_cnt   : high cycles within the last measured period
//   valid      : one-cycle pulse when period_cnt/high_cnt update
//   no_signal  : level, set while no rising edge seen within the timeout
module pwm_capture
    import pwm_pkg::*;
#(
    parameter  int unsigned RESOLUTION  = 10,
    parameter  int unsigned SYNC_STAGES = 2,
    localparam int unsigned CNT_W       = cnt_width(RESOLUTION)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic             valid,
    output logic             no_signal
);

    // The counter restarts at 1: the strobe cycle is the first cycle of the
    // new period, so rises N cycles apart read back as exactly N.
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    // Last count before the counter would hit all-ones (timeout point).
    localparam logic [CNT_W-1:0] TMO_AT  = {{(CNT_W-1){1'b1}}, 1'b0};

    pwm_state_e       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [CNT_W-1:0] hreg, hreg_d;
    logic [CNT_W-1:0] period_d, high_d;
    logic             valid_d, nosig_d;
    logic             rise, fall;

    pwm_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk    (clk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .rise   (rise),
        .fall   (fall)
    );

    // Next-state and output logic.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        hreg_d   = hreg;
        period_d = period_cnt;
        high_d   = high_cnt;
        valid_d  = 1'b0;
        nosig_d  = no_signal;

        case (state)
            IDLE: begin
                if (rise) begin
                    state_d = HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            HIGH, LOW: begin
                cnt_d = cnt + CNT_ONE;
                // A rise while still in HIGH (missed fall) closes the period too.
                if (rise) begin
                    period_d = cnt;
                    high_d   = hreg;
                    valid_d  = 1'b1;
                    nosig_d  = 1'b0;
                    cnt_d    = CNT_ONE;
                    state_d  = HIGH;
                end else begin
                    if (state == HIGH && fall) begin
                        hreg_d  = cnt;
                        state_d = LOW;
                    end
                    // Counter parks at all-ones in IDLE and never wraps.
                    if (cnt == TMO_AT) begin
                        state_d = IDLE;
                        nosig_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            hreg       <= '0;
            period_cnt <= '0;
            high_cnt   <= '0;
            valid      <= 1'b0;
            no_signal  <= 1'b1;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            hreg       <= hreg_d;
            period_cnt <= period_d;
            high_cnt   <= high_d;
            valid      <= valid_d;
            no_signal  <= nosig_d;
        end
    end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter RESOLUTION, default 10, sets the counter width; measurement width is CNT_W = RESOLUTION+1.
REQ-002 Parameter SYNC_STAGES, default 2, is the synchronizer depth on pwm_in; legal values are 2 or more.
REQ-003 clk  input  1  is the single clock; all logic SHALL be on its rising edge.
REQ-004 rst  input  1  is the reset, synchronous and active-low.
REQ-005 pwm_in  input  1  is the asynchronous PWM waveform to be measured.
REQ-006 period_cnt  output  CNT_W  holds the clk cycles between the last two rising edges of pwm_in.
REQ-007 high_cnt  output  CNT_W  holds the clk cycles pwm_in was high within the last measured period.
REQ-008 valid  output  1  is a one-cycle pulse when period_cnt and high_cnt update.
REQ-009 no_signal  output  1  is a level; high when no rising edge has occurred within the timeout.

Function
REQ-010 pwm_in SHALL pass through SYNC_STAGES flops, then an edge-detect register, producing rise and fall strobes.
REQ-011 FSM states SHALL be IDLE, HIGH and LOW.
REQ-012 IDLE: a rise strobe moves the FSM to HIGH and clears the cycle counter; no measurement is output.
REQ-013 HIGH: a fall strobe latches the current counter into an internal high register and moves the FSM to LOW.
REQ-014 LOW: a rise strobe SHALL, in that cycle, load period_cnt with the counter, load high_cnt with the high register, pulse valid, clear the counter, clear no_signal, and move the FSM to HIGH.
REQ-015 The counter SHALL increment every cycle outside IDLE.
REQ-016 The counter SHALL be defined so that a stable input with rising edges N cycles apart yields period_cnt = N and high cycles H yields high_cnt = H.
REQ-017 valid SHALL assert exactly one cycle after the registered rise strobe.
REQ-018 Total latency from a pwm_in rising edge to valid SHALL be SYNC_STAGES+2 cycles, and this SHALL be fixed.
REQ-019 period_cnt and high_cnt SHALL hold their values between valid pulses.
REQ-020 Timeout: if the counter reaches 2^CNT_W-1 in HIGH or LOW, the FSM SHALL go to IDLE, set no_signal, and leave the outputs unchanged.
REQ-021 The counter SHALL never wrap.
REQ-022 A 0% or 100% duty input (constant level) SHALL result in no_signal=1 and no valid pulses.
REQ-023 A high pulse of one synchronized cycle SHALL be measured as high_cnt = 1.
REQ-024 A rise strobe in HIGH is impossible; the FSM SHALL treat it as a rise strobe in LOW.
REQ-025 A fall strobe in IDLE or LOW SHALL be ignored.
REQ-026 The first rising edge after reset or after a timeout SHALL only start a measurement; the first valid follows the second rising edge.

Reset
REQ-027 When rst=0 at a clk edge: FSM to IDLE; counter, period_cnt, high_cnt and the high register to 0; valid to 0; no_signal to 1; synchronizer and edge flops to 0.
REQ-028 Reset asserted mid-measurement SHALL discard the partial measurement; no valid pulse is produced for it.
REQ-029 After reset release, a pwm_in that is already high SHALL produce a rise strobe only if the synchronizer observes a 0-to-1 transition.

Structure
REQ-030 A shared package pwm_pkg SHALL hold the FSM state enumeration (IDLE, HIGH, LOW) and the CNT_W derivation constant/function.
REQ-031 One sub-module, pwm_edge_sync, SHALL contain the synchronizer chain and the rise/fall strobe generation.
REQ-032 All other logic SHALL reside in pwm_capture.

Verification
REQ-033 Drive pwm_in from a 10-bit, duty-512 PWM generator on the same clk -> from the second valid onward, period_cnt=1024 and high_cnt=512 on every valid.
REQ-034 Use the same generator with duty 123 -> period_cnt=1024, high_cnt=123; valid pulses SHALL be spaced exactly 1024 cycles apart.
REQ-035 Hold pwm_in high for 3000 cycles after one measured period -> no_signal rises 2047 cycles after the last rise strobe, there is no valid, and the outputs keep their last values.
REQ-036 Apply a 1-cycle high pulse every 20 cycles -> high_cnt=1 and period_cnt=20.
REQ-037 Assert rst=0 for 1 cycle midway through a HIGH phase -> all outputs at reset values and no_signal=1; the first valid appears only after two subsequent rising edges, with correct counts.
REQ-038 Measure the latency from a pwm_in 0-to-1 change at a clk edge in LOW -> valid asserts SYNC_STAGES+2 cycles later.
